// File: rtl/dcache_direct_mapped.sv
// Direct-mapped, write-back, write-allocate data cache for the MEM stage.
// Misses stall the pipeline via is_ready while a 16-byte block is written back and/or refilled.
module dcache_direct_mapped #(
  parameter int LINE_COUNT = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         is_input_valid,
  input  logic [31:0]  addr,
  input  logic         mem_rw,
  input  logic [31:0]  din,
  output logic         is_ready,
  output logic         is_output_valid,
  output logic [31:0]  dout,
  output logic         is_hit,
  output logic         mem_req_valid,
  output logic         mem_req_write,
  output logic [31:0]  mem_req_addr,
  output logic [127:0] mem_req_wdata,
  input  logic         mem_req_ready,
  input  logic         mem_resp_valid,
  input  logic [127:0] mem_resp_rdata
);

  localparam int IDX = $clog2(LINE_COUNT);
  localparam int TAG = 28 - IDX;

  typedef enum logic [2:0] {
    IDLE, COMPARE, WRITEBACK, WB_WAIT, ALLOCATE, ALLOC_WAIT
  } state_t;

  state_t state, next_state;

  logic [31:0]           req_addr;
  logic [31:0]           req_din;
  logic                  req_rw;
  logic                  refilled;
  logic [LINE_COUNT-1:0] valid_bits;
  logic [LINE_COUNT-1:0] dirty_bits;
  logic [TAG-1:0]        tag_array  [LINE_COUNT];
  logic [127:0]          data_array [LINE_COUNT];
  logic [31:0]           hit_count;
  logic [31:0]           miss_count;

  logic [1:0]     offset;
  logic [IDX-1:0] index;
  logic [TAG-1:0] tag;
  logic [127:0]   line;
  logic [127:0]   store_line;
  logic           hit;
  logic           unused_bits;

  assign offset      = req_addr[3:2];
  assign index       = req_addr[4+IDX-1:4];
  assign tag         = req_addr[31:4+IDX];
  assign line        = data_array[index];
  assign hit         = valid_bits[index] && (tag_array[index] == tag);
  assign unused_bits = ^req_addr[1:0];

  always_comb begin
    store_line = line;
    store_line[{offset, 5'b00000} +: 32] = req_din;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Memory request fields are decoded from state so reset drops them on the reset edge.
  always_comb begin
    next_state    = state;
    is_ready      = 1'b0;
    mem_req_valid = 1'b0;
    mem_req_write = 1'b0;
    mem_req_addr  = 32'd0;
    mem_req_wdata = 128'd0;
    case (state)
      IDLE: begin
        is_ready = 1'b1;
        if (is_input_valid) next_state = COMPARE;
      end
      COMPARE: begin
        if (hit)                                        next_state = IDLE;
        else if (valid_bits[index] && dirty_bits[index]) next_state = WRITEBACK;
        else                                            next_state = ALLOCATE;
      end
      WRITEBACK: begin
        mem_req_valid = 1'b1;
        mem_req_write = 1'b1;
        mem_req_addr  = {tag_array[index], index, 4'b0000};
        mem_req_wdata = line;
        if (mem_req_ready) next_state = WB_WAIT;
      end
      WB_WAIT: begin
        if (mem_resp_valid) next_state = ALLOCATE;
      end
      ALLOCATE: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = {tag, index, 4'b0000};
        if (mem_req_ready) next_state = ALLOC_WAIT;
      end
      ALLOC_WAIT: begin
        if (mem_resp_valid) next_state = COMPARE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_bits      <= '0;
      dirty_bits      <= '0;
      req_addr        <= 32'd0;
      req_din         <= 32'd0;
      req_rw          <= 1'b0;
      refilled        <= 1'b0;
      dout            <= 32'd0;
      is_output_valid <= 1'b0;
      is_hit          <= 1'b0;
      hit_count       <= 32'd0;
      miss_count      <= 32'd0;
    end else begin
      is_output_valid <= 1'b0;
      is_hit          <= 1'b0;
      case (state)
        IDLE: begin
          if (is_input_valid) begin
            req_addr <= addr;
            req_din  <= din;
            req_rw   <= mem_rw;
            refilled <= 1'b0;
          end
        end
        COMPARE: begin
          if (hit) begin
            is_output_valid <= 1'b1;
            is_hit          <= !refilled;
            if (refilled) miss_count <= miss_count + 32'd1;
            else          hit_count  <= hit_count + 32'd1;
            if (req_rw) begin
              data_array[index] <= store_line;
              dirty_bits[index] <= 1'b1;
            end else begin
              dout <= line[{offset, 5'b00000} +: 32];
            end
          end
        end
        WB_WAIT: begin
          if (mem_resp_valid) dirty_bits[index] <= 1'b0;
        end
        ALLOC_WAIT: begin
          if (mem_resp_valid) begin
            data_array[index] <= mem_resp_rdata;
            tag_array[index]  <= tag;
            valid_bits[index] <= 1'b1;
            dirty_bits[index] <= 1'b0;
            refilled          <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
